// File: rtl/kpn_channel_pkg.sv
// Shared definitions for KPN channels: default word width, default channel
// depth and the read-side FSM state encoding.
// No ports. This package is imported by the channel FIFO and its storage.
package kpn_channel_pkg;

  localparam int KPN_DATA_WIDTH    = 16;
  localparam int KPN_CHANNEL_DEPTH = 8;

  // IDLE: no read outstanding. PENDING: a read arrived while empty and
  // completes as soon as a word is present.
  typedef enum logic {
    RD_IDLE    = 1'b0,
    RD_PENDING = 1'b1
  } rd_state_e;

endpackage

// File: rtl/kpn_fifo_mem.sv
// Channel storage: DEPTH x DATA_WIDTH array with one synchronous write port
// and one asynchronous read port. Contents are not reset.
// Ports:
//   clock  in  rising-edge clock
//   we     in  write enable
//   waddr  in  write address
//   wdata  in  write data
//   raddr  in  read address
//   rdata  out word stored at raddr (combinational)
module kpn_fifo_mem
  import kpn_channel_pkg::*;
#(
  parameter int DATA_WIDTH = KPN_DATA_WIDTH,
  parameter int DEPTH      = KPN_CHANNEL_DEPTH,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clock,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/kpn_channel_fifo.sv
// KPN channel: bounded FIFO between a producer and lcd_module with blocking
// read semantics. A read that finds the channel empty is held pending and
// completes automatically once a word arrives.
// Ports:
//   clock       in  rising-edge clock
//   reset_n     in  asynchronous active-low reset
//   wr          in  producer write request
//   entry_in    in  producer data, valid with wr
//   full        out count == DEPTH
//   rd          in  consumer read strobe (level; only its rising edge pops)
//   entry_1     out last popped word, held until the next pop
//   empty       out count == 0
//   rd_pending  out read FSM is in PENDING (blocking read waiting)
//   count       out number of stored words, 0..DEPTH
//   overflow    out sticky: a write was attempted while full
//
// Handshake: a write is accepted on any clock edge where wr=1 and full=0
// (full acts as ~ready); wr while full drops the word and sets overflow.
// A read is requested by a rising edge of rd; it is served at that edge when
// empty=0, otherwise on the first edge where empty=0. full/empty are decoded
// from registered count only, so both decisions use pre-edge state.
module kpn_channel_fifo
  import kpn_channel_pkg::*;
#(
  parameter int DATA_WIDTH = KPN_DATA_WIDTH,
  parameter int DEPTH      = KPN_CHANNEL_DEPTH,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  wr,
  input  logic [DATA_WIDTH-1:0] entry_in,
  output logic                  full,
  input  logic                  rd,
  output logic [DATA_WIDTH-1:0] entry_1,
  output logic                  empty,
  output logic                  rd_pending,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow
);

  localparam logic [ADDR_WIDTH:0] FULL_COUNT = (ADDR_WIDTH+1)'(DEPTH);

  rd_state_e             state_q, state_d;
  logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
  logic [ADDR_WIDTH:0]   count_q;
  logic                  rd_q;
  logic                  rd_edge;
  logic                  do_write;
  logic                  do_pop;
  logic [DATA_WIDTH-1:0] mem_rdata;

  assign empty      = (count_q == '0);
  assign full       = (count_q == FULL_COUNT);
  assign count      = count_q;
  assign rd_pending = (state_q == RD_PENDING);

  // Holding rd high must pop only once, so only the rising edge counts.
  assign rd_edge  = rd & ~rd_q;
  assign do_write = wr & ~full;

  always_comb begin
    state_d = state_q;
    do_pop  = 1'b0;
    unique case (state_q)
      RD_IDLE: begin
        if (rd_edge) begin
          if (!empty) do_pop  = 1'b1;
          else        state_d = RD_PENDING;
        end
      end
      RD_PENDING: begin
        // Further rd edges here are ignored: at most one read outstanding.
        if (!empty) begin
          do_pop  = 1'b1;
          state_d = RD_IDLE;
        end
      end
      default: state_d = RD_IDLE;
    endcase
  end

  kpn_fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_mem (
    .clock (clock),
    .we    (do_write),
    .waddr (wr_ptr),
    .wdata (entry_in),
    .raddr (rd_ptr),
    .rdata (mem_rdata)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= RD_IDLE;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count_q  <= '0;
      rd_q     <= 1'b0;
      entry_1  <= '0;
      overflow <= 1'b0;
    end else begin
      state_q <= state_d;
      rd_q    <= rd;
      if (do_write) wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
      if (do_pop) begin
        rd_ptr  <= rd_ptr + ADDR_WIDTH'(1);
        entry_1 <= mem_rdata;
      end
      unique case ({do_write, do_pop})
        2'b10:   count_q <= count_q + (ADDR_WIDTH+1)'(1);
        2'b01:   count_q <= count_q - (ADDR_WIDTH+1)'(1);
        default: count_q <= count_q;
      endcase
      if (wr && full) overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_kpn_channel_fifo.sv
// Testbench for kpn_channel_fifo: directed scenarios followed by a random
// phase, all compared each cycle against a queue-based channel model.
module tb_kpn_channel_fifo;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        wr;
  logic [15:0] entry_in;
  logic        full;
  logic        rd;
  logic [15:0] entry_1;
  logic        empty;
  logic        rd_pending;
  logic [3:0]  count;
  logic        overflow;

  int errors = 0;
  int checks = 0;

  // Reference model of the channel.
  logic [15:0] exp_q[$];
  logic [15:0] m_entry;
  bit          m_pending;
  bit          m_rd_q;
  bit          m_over;

  kpn_channel_fifo dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .wr         (wr),
    .entry_in   (entry_in),
    .full       (full),
    .rd         (rd),
    .entry_1    (entry_1),
    .empty      (empty),
    .rd_pending (rd_pending),
    .count      (count),
    .overflow   (overflow)
  );

  // ---------------- clock ----------------
  always #5 clock = ~clock;

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string where);
    check({where, ".entry_1"},    entry_1,             m_entry);
    check({where, ".count"},      16'(count),          16'(exp_q.size()));
    check({where, ".full"},       16'(full),           16'(exp_q.size() == 8));
    check({where, ".empty"},      16'(empty),          16'(exp_q.size() == 0));
    check({where, ".rd_pending"}, 16'(rd_pending),     16'(m_pending));
    check({where, ".overflow"},   16'(overflow),       16'(m_over));
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_entry   = '0;
    m_pending = 1'b0;
    m_rd_q    = 1'b0;
    m_over    = 1'b0;
  endtask

  // One clock of channel behaviour, from the pre-edge state.
  task automatic model_edge(input bit w, input logic [15:0] d, input bit r);
    bit was_empty, was_full, req, pop;
    was_empty = (exp_q.size() == 0);
    was_full  = (exp_q.size() == 8);
    req       = r && !m_rd_q;
    pop       = !was_empty && (m_pending || req);
    if (pop) m_entry = exp_q.pop_front();
    if (m_pending) m_pending = was_empty;
    else           m_pending = req && was_empty;
    if (w) begin
      if (was_full) m_over = 1'b1;
      else          exp_q.push_back(d);
    end
    m_rd_q = r;
  endtask

  // ---------------- driver ----------------
  task automatic step(input bit w, input logic [15:0] d, input bit r);
    wr       = w;
    entry_in = d;
    rd       = r;
    @(posedge clock);
    model_edge(w, d, r);
    #1;
    check_all("step");
  endtask

  task automatic pop_pulse();
    step(1'b0, 16'h0, 1'b1);
    step(1'b0, 16'h0, 1'b0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [15:0] w;
    reset_n  = 1'b0;
    wr       = 1'b0;
    rd       = 1'b0;
    entry_in = '0;
    model_reset();
    #23;
    check_all("reset");
    check("reset.count_const", 16'(count), 16'h0);
    reset_n = 1'b1;

    // 1: write two words, single-cycle rd pulse, then hold.
    step(1'b1, 16'h1234, 1'b0);
    step(1'b1, 16'h5678, 1'b0);
    step(1'b0, 16'h0,    1'b1);
    check("t1.entry_1", entry_1, 16'h1234);
    check("t1.count",   16'(count), 16'd1);
    for (int i = 0; i < 10; i++) step(1'b0, 16'h0, 1'b0);
    check("t1.held", entry_1, 16'h1234);

    // 2: three stored words, rd high for five cycles pops once.
    step(1'b1, 16'h0A0A, 1'b0);
    step(1'b1, 16'h0B0B, 1'b0);
    check("t2.count3", 16'(count), 16'd3);
    for (int i = 0; i < 5; i++) step(1'b0, 16'h0, 1'b1);
    step(1'b0, 16'h0, 1'b0);
    check("t2.count2", 16'(count), 16'd2);
    check("t2.entry_1", entry_1, 16'h5678);

    // 3: blocking read on empty channel.
    pop_pulse();
    pop_pulse();
    step(1'b0, 16'h0, 1'b1);
    check("t3.pending", 16'(rd_pending), 16'd1);
    check("t3.unchanged", entry_1, 16'h0B0B);
    step(1'b0, 16'h0, 1'b0);
    step(1'b1, 16'h0042, 1'b0);
    check("t3.count_n", 16'(count), 16'd1);
    step(1'b0, 16'h0, 1'b0);
    check("t3.entry_1", entry_1, 16'h0042);
    check("t3.pending0", 16'(rd_pending), 16'd0);
    check("t3.empty", 16'(empty), 16'd1);

    // 4: overfill, drain in order, refill across the pointer wrap.
    for (int i = 0; i < 9; i++) begin
      w = 16'($urandom);
      step(1'b1, w, 1'b0);
      if (i == 7) check("t4.full", 16'(full), 16'd1);
    end
    check("t4.overflow", 16'(overflow), 16'd1);
    for (int i = 0; i < 8; i++) pop_pulse();
    check("t4.empty", 16'(empty), 16'd1);
    for (int i = 0; i < 8; i++) step(1'b1, 16'($urandom), 1'b0);
    for (int i = 0; i < 8; i++) pop_pulse();

    // 5: simultaneous write and pop at count 4.
    for (int i = 0; i < 4; i++) step(1'b1, 16'h5000 + 16'(i), 1'b0);
    step(1'b1, 16'h5AAA, 1'b1);
    check("t5.count", 16'(count), 16'd4);
    check("t5.oldest", entry_1, 16'h5000);
    step(1'b0, 16'h0, 1'b0);
    for (int i = 0; i < 4; i++) pop_pulse();
    check("t5.tail", entry_1, 16'h5AAA);

    // 6: asynchronous reset while a read is pending.
    step(1'b0, 16'h0, 1'b1);
    check("t6.pending", 16'(rd_pending), 16'd1);
    @(negedge clock);
    reset_n = 1'b0;
    rd      = 1'b0;
    model_reset();
    #1;
    check_all("t6.async");
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) step(1'b0, 16'h0, 1'b0);
    check("t6.nopop", entry_1, 16'h0);
    step(1'b1, 16'h7777, 1'b0);
    pop_pulse();
    check("t6.after", entry_1, 16'h7777);

    // Random traffic.
    for (int i = 0; i < 400; i++)
      step(1'($urandom_range(0, 99) < 55), 16'($urandom), 1'($urandom_range(0, 2) == 0));
    for (int i = 0; i < 10; i++) pop_pulse();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
